// File: rtl/aes_block_packer_if.sv
// aes_block_packer_if: plaintext word, packed block, ciphertext block and ciphertext word handshakes.
interface aes_block_packer_if #(
  parameter int WORD_W = 32,
  parameter int WORDS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WORD_W-1:0]        in_data;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [WORD_W*WORDS-1:0]  blk_data;
  logic                     res_valid;
  logic                     res_ready;
  logic [WORD_W*WORDS-1:0]  res_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_W-1:0]        out_data;
  modport master (
    output in_valid, in_data, blk_ready, res_valid, res_data, out_ready,
    input  in_ready, blk_valid, blk_data, res_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, blk_ready, res_valid, res_data, out_ready,
    output in_ready, blk_valid, blk_data, res_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs plaintext words into AES blocks and unpacks ciphertext blocks into words.
// Optional AES_PACK_BSWAP_EN reverses the bytes of every word on both sides.
module aes_block_packer #(
  parameter int WORD_W = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  aes_block_packer_if.slave  bus,
  output logic               block_done_o,
  output logic [15:0]        blk_count_o,
  output logic               busy_o
);
  localparam int BLK_W = WORD_W * WORDS;
  localparam int CNT_W = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
  localparam logic [0:0] PK_FILL = 1'b0;
  localparam logic [0:0] PK_FULL = 1'b1;
  localparam logic [0:0] UP_IDLE = 1'b0;
  localparam logic [0:0] UP_DRAIN = 1'b1;
  logic [0:0]       pk_state;
  logic [0:0]       up_state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [BLK_W-1:0] pack_q;
  logic [BLK_W-1:0] shift_q;
  logic             block_done_q;
  logic [15:0]      blk_count_q;
  logic             in_hs;
  logic             blk_hs;
  logic             res_hs;
  logic             out_hs;

  function automatic logic [WORD_W-1:0] lane_swap(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
`ifdef AES_PACK_BSWAP_EN
    for (int i = 0; i < WORD_W / 8; i++) r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
`endif
    return r;
  endfunction

  assign bus.in_ready  = pk_state == PK_FILL;
  assign bus.blk_valid = pk_state == PK_FULL;
  assign bus.blk_data  = pack_q;
  assign bus.res_ready = up_state == UP_IDLE;
  assign bus.out_valid = up_state == UP_DRAIN;
  assign bus.out_data  = lane_swap(shift_q[BLK_W-1 -: WORD_W]);
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign blk_hs = bus.blk_valid && bus.blk_ready;
  assign res_hs = bus.res_valid && bus.res_ready;
  assign out_hs = bus.out_valid && bus.out_ready;
  assign block_done_o = block_done_q;
  assign blk_count_o  = blk_count_q;
  assign busy_o = in_cnt != '0 || pk_state == PK_FULL || up_state == UP_DRAIN;

  // Words shift in from the bottom, so word 0 ends up in the top lane once the block is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_state <= PK_FILL;
      in_cnt   <= '0;
      pack_q   <= '0;
    end else if (clear) begin
      pk_state <= PK_FILL;
      in_cnt   <= '0;
      pack_q   <= '0;
    end else begin
      if (in_hs) pack_q <= {pack_q[BLK_W-WORD_W-1:0], lane_swap(bus.in_data)};
      if (in_hs) in_cnt <= in_cnt == LAST ? '0 : in_cnt + 1'b1;
      pk_state <= blk_hs ? PK_FILL : (in_hs && in_cnt == LAST) ? PK_FULL : pk_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_state     <= UP_IDLE;
      out_cnt      <= '0;
      shift_q      <= '0;
      block_done_q <= 1'b0;
      blk_count_q  <= '0;
    end else if (clear) begin
      up_state     <= UP_IDLE;
      out_cnt      <= '0;
      shift_q      <= '0;
      block_done_q <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      shift_q      <= res_hs ? bus.res_data : out_hs ? shift_q << WORD_W : shift_q;
      out_cnt      <= res_hs ? '0 : out_hs ? (out_cnt == LAST ? '0 : out_cnt + 1'b1) : out_cnt;
      up_state     <= res_hs ? UP_DRAIN : (out_hs && out_cnt == LAST) ? UP_IDLE : up_state;
      block_done_q <= out_hs && out_cnt == LAST;
      blk_count_q  <= (out_hs && out_cnt == LAST) ? blk_count_q + 1'b1 : blk_count_q;
    end
  end
endmodule
